seg7_scan_decoder: RTL and testbench
====================================

Name: seg7_scan_decoder

Overview:
Receive-side counterpart of the 4-digit multiplexed 7-segment scan driver. It samples an active-low anode select and an active-low segment bus, which may be driven by another board or looped back from our own display driver. It reconstructs the four displayed BCD digits, flags patterns that are not legal digits, and signals each completed scan frame. Used for board-to-board display links and as a self-check monitor of the display path.

Parameters:
STABLE_CYCLES, 4, consecutive identical synchronized samples of {digit_in, display_in} required before the pair is accepted (range 2..255)
TIMEOUT_CYCLES, 65535, clk cycles without any accept before the outputs are declared stale (range 16..2^20-1)

Ports:
clk  input  1  system clock, the only clock
reset  input  1  asynchronous, active-high reset
digit_in  input  4  anode select, active-low one-hot; bit0 = rightmost digit; 4'b1111 = blank
display_in  input  7  segments {a,b,c,d,e,f,g}, active-low, a = bit6
bcd_out  output  16  {bcd3,bcd2,bcd1,bcd0}; each nibble is 0..9, or 4'hF for an illegal pattern
digit_valid  output  4  bit i = 1 once position i has been accepted since reset or since the last stale event
seg_err  output  4  bit i = 1 when the last accepted pattern for position i was illegal
frame_done  output  1  one-cycle pulse when all four positions have been accepted since the previous pulse
stale  output  1  1 when no accept has occurred for TIMEOUT_CYCLES cycles

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high, on ports clk and reset.
- Reset values:
  - bcd_out = 16'h0000, digit_valid = 0, seg_err = 0, frame_done = 0, stale = 0.
  - Sync flops load 4'b1111 / 7'b1111111 (blank). All counters and the seen mask = 0.
- Synchronizer: 2-flop synchronizer on all 11 input bits.
- Stability filter:
  - The counter runs while the synchronized pair is unchanged and restarts on any change.
  - A pair is accepted once per stable run, after STABLE_CYCLES identical samples.
  - Fixed latency: if the input changes before edge 1 and is then held, outputs update on edge 2+STABLE_CYCLES (edge 6 at default).
- Digit qualification:
  - The pair is processed only if digit_in has exactly one zero.
  - Blank (4'b1111) and multi-low patterns (e.g. 4'b1100) are ignored entirely: no output change, no frame or timeout effect.
- Segment decode, legal patterns:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
- On accept of position i:
  - Legal pattern: nibble i = value, seg_err[i] = 0.
  - Illegal pattern: nibble i = 4'hF, seg_err[i] = 1.
  - digit_valid[i] = 1 and seen[i] = 1.
- Frame FSM (states IDLE, COLLECT):
  - IDLE -> COLLECT on the first accept.
  - When seen becomes 4'b1111, frame_done pulses on the same edge that registers the completing nibble; seen clears and the FSM stays in COLLECT.
  - Accept order is irrelevant. Re-accepting an already-seen position updates its nibble and does not pulse frame_done.
- Timeout:
  - The counter clears on every accept and saturates.
  - On reaching TIMEOUT_CYCLES: stale = 1, digit_valid = 0, seen = 0, FSM -> IDLE. bcd_out and seg_err are retained.
  - The next accept clears stale and sets only that position's valid bit.
  - If an accept and the timeout occur in the same cycle, the accept wins.
- Reset mid-operation: all state returns to reset values immediately, and any partial frame is discarded.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package seg7_pkg:
  - Constants SEG_0..SEG_9, SEG_BLANK = 7'b1111111, DIGIT_BLANK = 4'b1111, BCD_ERR = 4'hF.
  - State enum {IDLE, COLLECT}.
  - Function onehot_low(4-bit) -> {ok, index[1:0]}.
- Sub-module seg7_to_bcd: combinational, 7-bit pattern -> {err, bcd[3:0]}. It is shared with other monitors of the display driver.

Test Plan:
1. Reset; hold digit_in = 1110, display_in = 0000110 for 10 cycles -> bcd_out = 16'h0003 exactly at edge 6; digit_valid = 0001, seg_err = 0, frame_done = 0.
2. Scan 1110/1001111, 1101/0010010, 1011/0000110, 0111/1001100, 20 cycles each -> bcd_out = 16'h4321 and frame_done pulses for exactly one cycle, coincident with the digit-3 update. Repeat the scan -> one more pulse.
3. Hold a pair for 3 cycles, then blank, then a 2-cycle glitch 1100/0000000 -> no output change, no frame_done.
4. 1011/1111111 held 10 cycles -> bcd2 = F, seg_err = 0100. Then 1011/0100100 -> bcd2 = 5, seg_err = 0000.
5. TIMEOUT_CYCLES = 100: complete a frame, then drive blank -> stale = 1 exactly 100 cycles after the last accept, digit_valid = 0, bcd_out = 16'h4321 retained. Next accept of digit0 -> stale = 0, digit_valid = 0001.
6. Assert reset after accepting two digits -> all outputs 0 asynchronously. After release, a full frame is needed before frame_done (no carry-over of seen).

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan decoder and other display-path monitors.
// Contents: active-low segment codes for 0..9, blank/error codes, frame FSM state
// type, and a helper that qualifies an active-low one-hot anode select.
package seg7_pkg;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned BCD_W  = 4;

    // Segment order {a,b,c,d,e,f,g}, active-low
    localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    localparam logic [DIGITS-1:0] DIGIT_BLANK = 4'b1111;
    localparam logic [BCD_W-1:0]  BCD_ERR     = 4'hF;

    typedef enum logic {
        IDLE,
        COLLECT
    } frame_state_t;

    typedef struct packed {
        logic       ok;
        logic [1:0] index;
    } digit_sel_t;

    // ok = exactly one low bit; index = position of that bit
    function automatic digit_sel_t onehot_low(input logic [DIGITS-1:0] digit);
        digit_sel_t sel;
        sel = '0;
        case (digit)
            4'b1110: sel = '{ok: 1'b1, index: 2'd0};
            4'b1101: sel = '{ok: 1'b1, index: 2'd1};
            4'b1011: sel = '{ok: 1'b1, index: 2'd2};
            4'b0111: sel = '{ok: 1'b1, index: 2'd3};
            default: sel = '0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational 7-segment pattern to BCD decoder.
// Ports: pattern (active-low {a..g}) -> bcd_c (0..9, or 4'hF when illegal),
//        err_c (1 when the pattern is not a legal digit).
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] pattern,
    output logic [BCD_W-1:0] bcd_c,
    output logic             err_c
);

    always_comb begin
        bcd_c = BCD_ERR;
        case (pattern)
            SEG_0:   bcd_c = 4'd0;
            SEG_1:   bcd_c = 4'd1;
            SEG_2:   bcd_c = 4'd2;
            SEG_3:   bcd_c = 4'd3;
            SEG_4:   bcd_c = 4'd4;
            SEG_5:   bcd_c = 4'd5;
            SEG_6:   bcd_c = 4'd6;
            SEG_7:   bcd_c = 4'd7;
            SEG_8:   bcd_c = 4'd8;
            SEG_9:   bcd_c = 4'd9;
            default: bcd_c = BCD_ERR;
        endcase
    end

    assign err_c = (bcd_c == BCD_ERR);

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive-side decoder for a 4-digit multiplexed active-low 7-segment bus.
// Ports: clk, reset (async, active-high); digit_in (active-low anode one-hot),
//        display_in (active-low {a..g}); bcd_out {bcd3..bcd0}, digit_valid,
//        seg_err, frame_done (1-cycle pulse per completed frame), stale.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DIGITS-1:0]         digit_in,
    input  logic [SEG_W-1:0]          display_in,
    output logic [DIGITS*BCD_W-1:0]   bcd_out,
    output logic [DIGITS-1:0]         digit_valid,
    output logic [DIGITS-1:0]         seg_err,
    output logic                      frame_done,
    output logic                      stale
);

    localparam int unsigned STAB_W = 9;
    localparam int unsigned TMO_W  = 20;

    localparam logic [STAB_W-1:0] STABLE_LAST = STAB_W'(STABLE_CYCLES);
    localparam logic [STAB_W-1:0] STABLE_SAT  = STAB_W'(STABLE_CYCLES + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_MAX     = TMO_W'(TIMEOUT_CYCLES);

    logic [DIGITS-1:0] digit_s1, digit_s2;
    logic [SEG_W-1:0]  seg_s1, seg_s2;
    logic [STAB_W-1:0] stab_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              pair_change;
    logic              accept;
    logic              tmo_hit;
    digit_sel_t        sel;
    logic [DIGITS-1:0] pos_mask;
    logic [BCD_W-1:0]  dec_bcd;
    logic              dec_err;

    frame_state_t      state, state_n;
    logic [DIGITS-1:0] seen, seen_n;
    logic [DIGITS-1:0] seen_acc;
    logic              frame_done_n;

    // Two-flop synchronizer, reset to the blank pattern
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_s1 <= DIGIT_BLANK;
            digit_s2 <= DIGIT_BLANK;
            seg_s1   <= SEG_BLANK;
            seg_s2   <= SEG_BLANK;
        end else begin
            digit_s1 <= digit_in;
            digit_s2 <= digit_s1;
            seg_s1   <= display_in;
            seg_s2   <= seg_s1;
        end
    end

    // stab_cnt = number of consecutive cycles the synchronized pair has held;
    // saturating one past the threshold makes the accept fire once per run.
    assign pair_change = ({digit_s1, seg_s1} != {digit_s2, seg_s2});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stab_cnt <= '0;
        end else if (pair_change) begin
            stab_cnt <= STAB_W'(1);
        end else if (stab_cnt != STABLE_SAT) begin
            stab_cnt <= stab_cnt + STAB_W'(1);
        end
    end

    assign sel      = onehot_low(digit_s2);
    assign accept   = (stab_cnt == STABLE_LAST) && sel.ok;
    assign pos_mask = DIGITS'(4'b0001 << sel.index);
    assign tmo_hit  = !accept && (tmo_cnt == TMO_LAST);

    seg7_to_bcd u_dec (
        .pattern (seg_s2),
        .bcd_c   (dec_bcd),
        .err_c   (dec_err)
    );

    // Idle counter: cleared by accepts, saturates at the timeout value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (accept) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TMO_MAX) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    // Per-digit result registers; bcd_out/seg_err survive a timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd_out     <= '0;
            seg_err     <= '0;
            digit_valid <= '0;
            stale       <= 1'b0;
        end else if (accept) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (sel.index == 2'(i)) begin
                    bcd_out[i*BCD_W +: BCD_W] <= dec_bcd;
                    seg_err[i]                <= dec_err;
                end
            end
            digit_valid <= digit_valid | pos_mask;
            stale       <= 1'b0;
        end else if (tmo_hit) begin
            digit_valid <= '0;
            stale       <= 1'b1;
        end
    end

    // Frame FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            seen       <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            seen       <= seen_n;
            frame_done <= frame_done_n;
        end
    end

    // Frame FSM next state: collect positions, pulse when all four are seen
    assign seen_acc = seen | pos_mask;

    always_comb begin
        state_n      = state;
        seen_n       = seen;
        frame_done_n = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = COLLECT;
                    seen_n  = pos_mask;
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (seen_acc == DIGIT_BLANK) begin
                        frame_done_n = 1'b1;
                        seen_n       = '0;
                    end else begin
                        seen_n = seen_acc;
                    end
                end else if (tmo_hit) begin
                    state_n = IDLE;
                    seen_n  = '0;
                end
            end
            default: begin
                state_n = IDLE;
                seen_n  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed self-checking bench for seg7_scan_decoder (STABLE_CYCLES=4, TIMEOUT_CYCLES=100).
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  digit_in;
    logic [6:0]  display_in;
    logic [15:0] bcd_out;
    logic [3:0]  digit_valid;
    logic [3:0]  seg_err;
    logic        frame_done;
    logic        stale;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    always #5 clk = ~clk;

    seg7_scan_decoder #(
        .STABLE_CYCLES  (4),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .digit_in    (digit_in),
        .display_in  (display_in),
        .bcd_out     (bcd_out),
        .digit_valid (digit_valid),
        .seg_err     (seg_err),
        .frame_done  (frame_done),
        .stale       (stale)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive a pair, then run n edges sampling 1 ns after each; count frame pulses
    task automatic drive(input logic [3:0] d, input logic [6:0] s, input int n);
        digit_in   = d;
        display_in = s;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (frame_done === 1'b1) pulses++;
        end
    endtask

    task automatic scan_4321();
        drive(4'b1110, 7'b1001111, 20);
        drive(4'b1101, 7'b0010010, 20);
        drive(4'b1011, 7'b0000110, 20);
        drive(4'b0111, 7'b1001100, 20);
    endtask

    initial begin
        reset      = 1'b1;
        digit_in   = 4'b1111;
        display_in = 7'b1111111;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bcd",   32'(bcd_out),     32'h0);
        check("rst_valid", 32'(digit_valid), 32'h0);
        check("rst_err",   32'(seg_err),     32'h0);
        check("rst_fd",    32'(frame_done),  32'h0);
        check("rst_stale", 32'(stale),       32'h0);
        reset = 1'b0;

        // 1: fixed latency, update exactly on edge 6
        drive(4'b1110, 7'b0000110, 5);
        check("t1_bcd_e5", 32'(bcd_out), 32'h0000);
        drive(4'b1110, 7'b0000110, 1);
        check("t1_bcd_e6", 32'(bcd_out),     32'h0003);
        check("t1_valid",  32'(digit_valid), 32'h1);
        check("t1_err",    32'(seg_err),     32'h0);
        check("t1_fd",     32'(frame_done),  32'h0);
        drive(4'b1110, 7'b0000110, 4);

        // 2: full scan, single pulse coincident with digit-3 update
        pulses = 0;
        drive(4'b1110, 7'b1001111, 20);
        drive(4'b1101, 7'b0010010, 20);
        drive(4'b1011, 7'b0000110, 20);
        drive(4'b0111, 7'b1001100, 5);
        check("t2_fd_e5",  32'(frame_done), 32'h0);
        check("t2_bcd_e5", 32'(bcd_out),    32'h0321);
        drive(4'b0111, 7'b1001100, 1);
        check("t2_fd_e6",  32'(frame_done), 32'h1);
        check("t2_bcd_e6", 32'(bcd_out),    32'h4321);
        drive(4'b0111, 7'b1001100, 14);
        check("t2_pulses1", 32'(pulses),      32'd1);
        check("t2_valid",   32'(digit_valid), 32'hF);
        scan_4321();
        check("t2_pulses2", 32'(pulses),  32'd2);
        check("t2_bcd2",    32'(bcd_out), 32'h4321);

        // 3: short hold, blank and multi-low glitch are all ignored
        drive(4'b1110, 7'b0000000, 3);
        drive(4'b1111, 7'b1111111, 10);
        drive(4'b1100, 7'b0000000, 2);
        drive(4'b1111, 7'b1111111, 10);
        check("t3_bcd",    32'(bcd_out),     32'h4321);
        check("t3_valid",  32'(digit_valid), 32'hF);
        check("t3_err",    32'(seg_err),     32'h0);
        check("t3_pulses", 32'(pulses),      32'd2);

        // 4: illegal pattern then legal on digit 2
        drive(4'b1011, 7'b1111111, 10);
        check("t4_bcd_err", 32'(bcd_out), 32'h4F21);
        check("t4_err_set", 32'(seg_err), 32'h4);
        drive(4'b1011, 7'b0100100, 10);
        check("t4_bcd_ok",  32'(bcd_out), 32'h4521);
        check("t4_err_clr", 32'(seg_err), 32'h0);

        // 5: timeout exactly 100 cycles after the last accept
        pulses = 0;
        drive(4'b1110, 7'b1001111, 20);
        drive(4'b1101, 7'b0010010, 20);
        drive(4'b1011, 7'b0000110, 20);
        drive(4'b0111, 7'b1001100, 6);
        check("t5_fd", 32'(frame_done), 32'h1);
        drive(4'b1111, 7'b1111111, 99);
        check("t5_stale_99", 32'(stale), 32'h0);
        drive(4'b1111, 7'b1111111, 1);
        check("t5_stale_100", 32'(stale),       32'h1);
        check("t5_valid_clr", 32'(digit_valid), 32'h0);
        check("t5_bcd_kept",  32'(bcd_out),     32'h4321);
        drive(4'b1110, 7'b0000001, 5);
        check("t5_stale_hold", 32'(stale), 32'h1);
        drive(4'b1110, 7'b0000001, 1);
        check("t5_stale_clr", 32'(stale),       32'h0);
        check("t5_valid_one", 32'(digit_valid), 32'h1);
        check("t5_bcd_new",   32'(bcd_out),     32'h4320);

        // 6: asynchronous reset discards the partial frame
        drive(4'b1110, 7'b0000001, 14);
        drive(4'b1101, 7'b0010010, 20);
        check("t6_valid_pre", 32'(digit_valid), 32'h3);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_bcd",   32'(bcd_out),     32'h0);
        check("t6_rst_valid", 32'(digit_valid), 32'h0);
        check("t6_rst_stale", 32'(stale),       32'h0);
        digit_in   = 4'b1111;
        display_in = 7'b1111111;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        pulses = 0;
        drive(4'b1011, 7'b0000110, 20);
        drive(4'b0111, 7'b1001100, 20);
        check("t6_no_carry", 32'(pulses),      32'd0);
        check("t6_valid_hi", 32'(digit_valid), 32'hC);
        drive(4'b1110, 7'b1001111, 20);
        drive(4'b1101, 7'b0010010, 20);
        check("t6_pulse", 32'(pulses),  32'd1);
        check("t6_bcd",   32'(bcd_out), 32'h4321);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
